// File: rtl/mem_pkg.sv
// Shared definitions for the memory block mover: bus widths, op encodings
// and the control FSM state type.
package mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 31;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    // Increment step for addresses and the remaining-word counter.
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_block_mover.sv
// Memory-bus initiator performing block COPY and block FILL against the
// 4096 x 31-bit main memory.
//
// Bus handshake: a request is held (read or write enable high, address and
// write data stable) from its first cycle through the cycle in which the
// memory pulses mem_finish. A write is committed by the memory at the end of
// the request's first cycle; read data is valid the cycle after mem_finish.
// The memory ignores a request held during its finish cycle, so presenting a
// new address in the following cycle is a legal back-to-back request. Read
// and write enables are never high together. All bus outputs are decoded
// from registers only.
module mem_block_mover
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_finish,
    input  logic [DATA_W-1:0] mem_read_data,
    output state_t            dbg_state
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_op;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              w_last;

    // The word being written is the final one of the block.
    assign w_last = (r_remaining == ADDR_ONE);

    // State register; reset forces IDLE immediately, even mid-block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: COPY loops READ/CAPTURE/WRITE, FILL stays in WRITE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start && (count != '0)) begin
                    w_next_state = (op == OP_FILL) ? WRITE : READ;
                end
            end
            READ: begin
                if (mem_finish) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next_state = WRITE;
            end
            WRITE: begin
                if (mem_finish) begin
                    if (w_last) begin
                        w_next_state = IDLE;
                    end else if (r_op == OP_FILL) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = READ;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, read-data capture, per-word advance and done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op        <= OP_COPY;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_fill      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op        <= op;
                        r_src       <= src_addr;
                        r_dst       <= dst_addr;
                        r_remaining <= count;
                        r_fill      <= fill_data;
                        // An empty block completes without touching memory.
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    r_data <= mem_read_data;
                end
                WRITE: begin
                    if (mem_finish) begin
                        // Addresses wrap naturally at 2^ADDR_W.
                        r_src       <= r_src + ADDR_ONE;
                        r_dst       <= r_dst + ADDR_ONE;
                        r_remaining <= r_remaining - ADDR_ONE;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and status outputs, decoded purely from registered state.
    always_comb begin
        busy             = (r_state != IDLE);
        done             = r_done;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        dbg_state        = r_state;
        case (r_state)
            READ: begin
                mem_read_enable = 1'b1;
                mem_addr        = r_src;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                mem_addr         = r_dst;
                mem_write_data   = (r_op == OP_FILL) ? r_fill : r_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Memory-bus initiator that performs block copy and block fill operations against the 4096-word × 31-bit main memory. It drives the memory's request/finish handshake (read_enable / write_enable / finish, 12-bit address, 31-bit data), freeing the control unit from per-word sequencing. It sits between the control unit, which issues `start` with operands, and the main memory block, which is the responder.

## Interface
- ADDR_W, 12, word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 31, memory word width.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- op  in  1  0 = COPY, 1 = FILL.
- src_addr  in  ADDR_W  first source word (COPY only).
- dst_addr  in  ADDR_W  first destination word.
- count  in  ADDR_W  number of words to move, 0 to 4095.
- fill_data  in  DATA_W  word written by FILL.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- mem_read_enable  out  1  read request to memory.
- mem_write_enable  out  1  write request to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_finish  in  1  memory completion pulse.
- mem_read_data  in  DATA_W  memory read data; valid the cycle after `mem_finish`.

## Operation
- **Command capture.** On `start` in IDLE, latch `op`, src, dst, count and fill_data into internal registers. The inputs may change afterwards.
- **count = 0.** No memory access. `done` pulses in the next cycle; `busy` stays low.
- **States:**
  - IDLE → READ (COPY) or WRITE (FILL), when `start` is seen with count ≠ 0.
  - READ: `mem_read_enable` = 1, `mem_addr` = src. On `mem_finish` → CAPTURE.
  - CAPTURE: both enables low. Latch `mem_read_data` into the data register → WRITE.
  - WRITE: `mem_write_enable` = 1, `mem_addr` = dst, `mem_write_data` = data register (COPY) or fill_data (FILL). On `mem_finish`: src+1, dst+1, remaining−1. If remaining was 1 → IDLE with `done`. Otherwise → READ (COPY) or stay in WRITE at the new address (FILL).
- **Protocol rules.**
  - Enables, `mem_addr` and `mem_write_data` are decoded from registers only; there is no combinational path from any input to any output.
  - Address and data stay stable from request assertion through the `mem_finish` cycle.
  - The initiator never asserts read and write enables together.
  - The memory ignores a request held during its finish cycle. This makes a new address in the following cycle a legal back-to-back request.
- **Arithmetic.** src and dst increment modulo 2^ADDR_W (4095 wraps to 0). Copy direction is ascending only; when dst overlaps src, the copy replicates forward with no correction.
- **Ignored inputs.** `start` while busy is ignored. `mem_finish` outside READ/WRITE is ignored.
- **Reset.** Asynchronous reset, including mid-operation, forces IDLE immediately. Reset values: `busy`, `done`, both enables = 0; `mem_addr` = 0; `mem_write_data` = 0; internal registers = 0. A partially completed block is not rolled back.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- **COPY, per word: 5 cycles** (READ ×2, CAPTURE, WRITE ×2). `done` is high in cycle 5N+1.
- **FILL, per word: 2 cycles.** `done` is high in cycle 2N+1.
- `busy` is high from cycle 1 through the final `mem_finish` cycle, and low in the `done` cycle.
- A new `start` is accepted in the `done` cycle.
- Memory write commit:
  - The memory commits a write on the edge that ends the first cycle of a request.
  - For a read, the memory registers data on the edge that ends the finish cycle.

## Structure
- Shared package `mem_pkg` holds:
  - ADDR_W, DATA_W;
  - the op encodings OP_COPY / OP_FILL;
  - the state enum {IDLE, READ, CAPTURE, WRITE}.
- Single module; no sub-module. The memory block is instantiated only in the bench, as the responder.

## Test plan
- **Fill.** FILL dst=0o100, count=4, fill_data=31'h1234_5678.
  - Words 0o100–0o103 read back 31'h1234_5678; 0o104 is unchanged.
  - `done` in cycle 9; `busy` high cycles 1–8.
- **Copy.** COPY src=0o2000, dst=0o3000, count=3, with source preloaded with 1, 2, 3.
  - Destination words hold 1, 2, 3.
  - `done` in cycle 16.
  - Enables are never both high.
- **Wrap.** FILL dst=0o7776, count=4.
  - Words 0o7776, 0o7777, 0, 1 are written.
  - Address sequence on `mem_addr` during WRITE is 7776, 7777, 0000, 0001.
- **Zero count and busy start.**
  - count=0 → `done` in cycle 1, no enables asserted.
  - `start` pulsed during a busy COPY → ignored; the original operation completes unchanged.
- **Reset mid-operation.** Drop `resetn` during the READ state of word 2 of a COPY count=5.
  - All outputs go to 0 asynchronously.
  - Words 0–1 are copied, words 2–4 are untouched.
  - A fresh FILL after reset completes normally.
- **Overlapping copy.** COPY src=10, dst=11, count=3, with word 10 = 7 → words 11–13 all read back 7.
